// File: rtl/sram22_1r1w_model.sv
// Simple-dual-port SRAM behavioural model: one write port, one read port,
// per-lane write mask, selectable read latency (1 or 2), selectable
// read-during-write policy, and a post-reset clear sweep signalled by busy.
module sram22_1r1w_model #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int WMASK_WIDTH  = 4,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0,
  parameter int INIT_CLEAR   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   busy,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   re,
  input  logic [ADDR_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid
);

  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;

  // Reject configurations the model cannot represent.
  if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask_width
    $fatal(1, "sram22_1r1w_model: DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $fatal(1, "sram22_1r1w_model: READ_LATENCY must be 1 or 2");
  end
  if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_bad_rdw_mode
    $fatal(1, "sram22_1r1w_model: RDW_MODE must be 0, 1 or 2");
  end

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  // Storage
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  // Control state
  state_e                state_q,         state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q,       clr_cnt_d;
  logic                  busy_q,          busy_d;

  // Read pipeline and output registers
  logic                  rd_pipe_valid_q, rd_pipe_valid_d;
  logic [DATA_WIDTH-1:0] rd_pipe_data_q,  rd_pipe_data_d;
  logic [DATA_WIDTH-1:0] dout_q,          dout_d;
  logic                  dout_valid_q,    dout_valid_d;

  // Port acceptance and datapath intermediates
  logic                  ready;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Both ports are only honoured once the clear sweep has finished;
  // a write with an empty mask changes nothing and is not treated as a write.
  always_comb begin
    ready   = (state_q == ST_READY);
    wr_fire = ready && we && (|wmask);
    rd_fire = ready && re;
  end

  // Merge the incoming lanes into the currently stored word.
  // NOTE: every always_comb output gets a default assignment first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_word = mem[waddr];
    for (int k = 0; k < WMASK_WIDTH; k++) begin
      if (wmask[k]) begin
        wr_word[k*LANE_WIDTH +: LANE_WIDTH] = din[k*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // Read word, with the same-address read-during-write policy applied.
  always_comb begin
    rd_word = mem[raddr];
    if (wr_fire && (waddr == raddr)) begin
      case (RDW_MODE)
        1:       rd_word = wr_word;
        2:       rd_word = 'x;
        default: rd_word = mem[raddr];
      endcase
    end
  end

  // Single array write port: sweep zeros while clearing, user data when ready.
  // The array is never touched on an edge where rst is high.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wr_word;
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
      end else if (wr_fire) begin
        mem_we = 1'b1;
      end
    end
  end

  // Clear-sweep sequencing: step through every address, then hand over.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
      if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = ST_READY;
        busy_d  = 1'b0;
      end
    end
  end

  // Read return path: direct for latency 1, through one staging register
  // for latency 2. dout holds its value whenever nothing completes.
  always_comb begin
    rd_pipe_valid_d = 1'b0;
    rd_pipe_data_d  = rd_pipe_data_q;
    dout_d          = dout_q;
    dout_valid_d    = 1'b0;
    if (READ_LATENCY == 1) begin
      if (rd_fire) begin
        dout_d       = rd_word;
        dout_valid_d = 1'b1;
      end
    end else begin
      if (rd_fire) begin
        rd_pipe_valid_d = 1'b1;
        rd_pipe_data_d  = rd_word;
      end
      if (rd_pipe_valid_q) begin
        dout_d       = rd_pipe_data_q;
        dout_valid_d = 1'b1;
      end
    end
  end

  // Control and read-path registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_q       <= '0;
      busy_q          <= (INIT_CLEAR != 0);
      rd_pipe_valid_q <= 1'b0;
      rd_pipe_data_q  <= '0;
      dout_q          <= '0;
      dout_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      clr_cnt_q       <= clr_cnt_d;
      busy_q          <= busy_d;
      rd_pipe_valid_q <= rd_pipe_valid_d;
      rd_pipe_data_q  <= rd_pipe_data_d;
      dout_q          <= dout_d;
      dout_valid_q    <= dout_valid_d;
    end
  end

  // Array write.
  // NOTE: the storage array has no reset branch; clearing is done by the
  // sweep, one word per edge, so it maps onto a real RAM macro.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign busy       = busy_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
